// File: rtl/tl_ul_ram_responder_pkg.sv
// tl_ul_pkg: TileLink-UL opcodes, D response record and responder FSM states
package tl_ul_pkg;
  localparam logic [2:0] A_PUT_FULL = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET = 3'd4;
  localparam logic [2:0] A_INTENT = 3'd5;
  localparam logic [2:0] D_ACCESS_ACK = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;
  localparam int REC_SIZE_W = 3;
  localparam int REC_SOURCE_W = 7;
  localparam int REC_DATA_W = 32;
  typedef struct packed {
    logic [2:0] opcode;
    logic [REC_SIZE_W-1:0] size;
    logic [REC_SOURCE_W-1:0] source;
    logic denied;
    logic corrupt;
    logic [REC_DATA_W-1:0] data;
  } d_rec_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rsp_state_e;
endpackage

// File: rtl/tl_ul_ram_responder_if.sv
// tl_ul_ram_responder_if: TileLink-UL A/D channel bundle
interface tl_ul_ram_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SOURCE_W = 7,
  parameter int SIZE_W = 3
);
  logic a_valid;
  logic a_ready;
  logic [2:0] a_opcode;
  logic [2:0] a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic d_valid;
  logic d_ready;
  logic [2:0] d_opcode;
  logic [SIZE_W-1:0] d_size;
  logic [SOURCE_W-1:0] d_source;
  logic d_denied;
  logic d_corrupt;
  logic [DATA_W-1:0] d_data;
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
  );
  modport slave (
    input a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_ul_ram_responder_fifo.sv
// tl_ul_resp_fifo: synchronous FIFO of D response records
module tl_ul_resp_fifo
  import tl_ul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  d_rec_t wdata,
  output d_rec_t rdata,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  d_rec_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) mem[wp] <= wdata;
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/tl_ul_ram_responder.sv
// tl_ul_ram_responder: TileLink-UL RAM manager model with delayed D responses
module tl_ul_ram_responder
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = REC_DATA_W,
  parameter int SOURCE_W = REC_SOURCE_W,
  parameter int SIZE_W = REC_SIZE_W,
  parameter int MEM_WORDS = 1024,
  parameter int QDEPTH = 2
) (
  input logic clock,
  input logic reset,
  input logic [3:0] resp_delay,
  tl_ul_ram_responder_if.slave tl
);
  localparam int LANES = DATA_W / 8;
  localparam int LG = $clog2(LANES);
  localparam int IW = $clog2(MEM_WORDS);
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic fire, pop, full, empty;
  logic is_put, is_get, is_hint, bad_size, bad_idx, bad_align, denied;
  logic [IW-1:0] idx;
  logic [3:0] cnt, cnt_n;
  logic unused_param;
  rsp_state_e state, state_n;
  d_rec_t rec_in, head;
  assign unused_param = ^tl.a_param;
  assign fire = tl.a_valid & tl.a_ready;
  assign idx = tl.a_address[LG +: IW];
  assign is_put = tl.a_opcode == A_PUT_FULL || tl.a_opcode == A_PUT_PARTIAL;
  assign is_get = tl.a_opcode == A_GET;
  assign is_hint = tl.a_opcode == A_INTENT;
  assign bad_size = tl.a_size > SIZE_W'(LG);
  assign bad_idx = (tl.a_address >> LG) >= ADDR_W'(MEM_WORDS);
  assign bad_align = (tl.a_address & ((ADDR_W'(1) << tl.a_size) - ADDR_W'(1))) != '0;
  assign denied = ~(is_put | is_get | is_hint) | bad_size | bad_idx | bad_align;
  assign rec_in.opcode = is_put ? D_ACCESS_ACK : is_hint ? D_HINT_ACK : D_ACCESS_ACK_DATA;
  assign rec_in.size = tl.a_size;
  assign rec_in.source = tl.a_source;
  assign rec_in.denied = denied;
  assign rec_in.corrupt = denied & ~is_put & ~is_hint;
  assign rec_in.data = (is_get & ~denied) ? mem[idx] : '0;
  assign tl.a_ready = ~reset & ~full;
  assign tl.d_valid = state == S_RESP;
  assign tl.d_opcode = tl.d_valid ? head.opcode : '0;
  assign tl.d_size = tl.d_valid ? head.size : '0;
  assign tl.d_source = tl.d_valid ? head.source : '0;
  assign tl.d_denied = tl.d_valid & head.denied;
  assign tl.d_corrupt = tl.d_valid & head.corrupt;
  assign tl.d_data = tl.d_valid ? head.data : '0;
  assign pop = tl.d_valid & tl.d_ready;
  tl_ul_resp_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clock), .rst(reset), .push(fire), .pop(pop),
    .wdata(rec_in), .rdata(head), .full(full), .empty(empty)
  );
  // byte-masked RAM write for accepted, non-denied Puts
  always_ff @(posedge clock) begin
    if (fire & is_put & ~denied)
      for (int i = 0; i < LANES; i++)
        if (tl.a_mask[i]) mem[idx][8*i +: 8] <= tl.a_data[8*i +: 8];
  end
  // responder state and delay counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // IDLE loads the delay, WAIT counts it down, RESP holds until d_ready
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (!empty) begin
        cnt_n = resp_delay;
        state_n = resp_delay != '0 ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt == 4'd1 ? S_RESP : S_WAIT;
      end
      S_RESP: state_n = tl.d_ready ? S_IDLE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// tb_tl_ul_ram_responder: directed self-checking bench for tl_ul_ram_responder
module tb_tl_ul_ram_responder;
  logic clock = 0;
  logic reset;
  logic [3:0] resp_delay;
  int checks = 0;
  int errors = 0;
  tl_ul_ram_responder_if #(.ADDR_W(32), .DATA_W(32), .SOURCE_W(7), .SIZE_W(3)) tl ();
  tl_ul_ram_responder #(.MEM_WORDS(1024), .QDEPTH(2)) dut (
    .clock(clock), .reset(reset), .resp_delay(resp_delay), .tl(tl)
  );
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] sz, input logic [6:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    tl.a_valid = 1;
    tl.a_opcode = op;
    tl.a_param = 0;
    tl.a_size = sz;
    tl.a_source = src;
    tl.a_address = addr;
    tl.a_mask = mask;
    tl.a_data = data;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [6:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int k = 0;
    drive(op, sz, src, addr, mask, data);
    while (!tl.a_ready && k < 20) begin
      tick();
      k++;
    end
    chk("send_ready", tl.a_ready, 1);
    tick();
    tl.a_valid = 0;
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [2:0] op,
                             input logic [2:0] sz, input logic [6:0] src, input logic den,
                             input logic cor, input logic [31:0] data);
    int k = 0;
    while (!tl.d_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_op"}, tl.d_opcode, op);
    chk({tag, "_size"}, tl.d_size, sz);
    chk({tag, "_src"}, tl.d_source, src);
    chk({tag, "_den"}, tl.d_denied, den);
    chk({tag, "_cor"}, tl.d_corrupt, cor);
    chk({tag, "_data"}, tl.d_data, data);
    tick();
  endtask

  initial begin
    logic [6:0] got_src [3];
    logic [31:0] got_data [3];
    int n;
    logic fired, seen;
    reset = 1;
    resp_delay = 0;
    tl.d_ready = 1;
    drive(0, 0, 0, 0, 0, 0);
    tl.a_valid = 0;
    tick();
    tick();
    chk("rst_a_ready", tl.a_ready, 0);
    chk("rst_d_valid", tl.d_valid, 0);
    chk("rst_d_opcode", tl.d_opcode, 0);
    chk("rst_d_source", tl.d_source, 0);
    chk("rst_d_data", tl.d_data, 0);
    reset = 0;
    tick();
    chk("post_rst_a_ready", tl.a_ready, 1);

    send(0, 2, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    expect_resp("putfull", 1, 0, 2, 1, 0, 0, 0);
    send(4, 2, 2, 32'h10, 4'hF, 0);
    expect_resp("get1", 1, 1, 2, 2, 0, 0, 32'hDEADBEEF);
    send(1, 1, 3, 32'h10, 4'h3, 32'h00001234);
    expect_resp("putpart", 1, 0, 1, 3, 0, 0, 0);
    send(4, 2, 4, 32'h10, 4'hF, 0);
    expect_resp("get2", 1, 1, 2, 4, 0, 0, 32'hDEAD1234);

    send(4, 2, 10, 32'h1000, 4'hF, 0);
    expect_resp("get_oob", 1, 1, 2, 10, 1, 1, 0);
    send(4, 3, 11, 32'h10, 4'hF, 0);
    expect_resp("get_sz3", 1, 1, 3, 11, 1, 1, 0);
    send(4, 2, 12, 32'h12, 4'hF, 0);
    expect_resp("get_misal", 1, 1, 2, 12, 1, 1, 0);
    send(0, 2, 13, 32'h0, 4'hF, 32'h11223344);
    expect_resp("put0", 1, 0, 2, 13, 0, 0, 0);
    send(0, 2, 14, 32'h1000, 4'hF, 32'hFFFFFFFF);
    expect_resp("put_oob", 1, 0, 2, 14, 1, 0, 0);
    send(4, 2, 15, 32'h0, 4'hF, 0);
    expect_resp("get0", 1, 1, 2, 15, 0, 0, 32'h11223344);

    tl.d_ready = 0;
    send(4, 2, 5, 32'h10, 4'hF, 0);
    send(4, 2, 6, 32'h0, 4'hF, 0);
    chk("full_a_ready", tl.a_ready, 0);
    drive(4, 2, 7, 32'h10, 4'hF, 0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", tl.d_valid, 1);
      chk("stall_src", tl.d_source, 5);
      chk("stall_data", tl.d_data, 32'hDEAD1234);
      chk("stall_a_ready", tl.a_ready, 0);
      tick();
    end
    tl.d_ready = 1;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      if (tl.d_valid) begin
        got_src[n] = tl.d_source;
        got_data[n] = tl.d_data;
        n++;
      end
      fired = tl.a_valid & tl.a_ready;
      tick();
      if (fired) tl.a_valid = 0;
    end
    chk("order_count", n, 3);
    chk("order_src0", got_src[0], 5);
    chk("order_src1", got_src[1], 6);
    chk("order_src2", got_src[2], 7);
    chk("order_data1", got_data[1], 32'h11223344);
    chk("order_data2", got_data[2], 32'hDEAD1234);

    resp_delay = 3;
    send(4, 2, 8, 32'h10, 4'hF, 0);
    expect_resp("delay3", 4, 1, 2, 8, 0, 0, 32'hDEAD1234);
    resp_delay = 0;
    send(2, 2, 20, 32'h10, 4'hF, 0);
    expect_resp("atomic", 1, 1, 2, 20, 1, 1, 0);
    send(5, 2, 21, 32'h10, 4'hF, 0);
    expect_resp("intent", 1, 2, 2, 21, 0, 0, 0);

    tl.d_ready = 0;
    send(4, 2, 9, 32'h10, 4'hF, 0);
    tick();
    chk("pre_rst_valid", tl.d_valid, 1);
    reset = 1;
    tick();
    chk("mid_rst_valid", tl.d_valid, 0);
    chk("mid_rst_a_ready", tl.a_ready, 0);
    reset = 0;
    tick();
    chk("after_rst_a_ready", tl.a_ready, 1);
    tl.d_ready = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      seen |= tl.d_valid;
      tick();
    end
    chk("no_stale_resp", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
